// File: rtl/vga_stream_pkg.sv
// Shared constants and types for the VGA stream monitor.
// Defaults describe 640x480@60 timing and CRC-16-CCITT.
package vga_stream_pkg;

  localparam int DEF_H_VIS = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_VIS = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_LOCK_FRAMES = 2;

  localparam int H_TOTAL =
    DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL =
    DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_START = DEF_H_VIS + DEF_H_FP;
  localparam int H_SYNC_END = H_SYNC_START + DEF_H_SYNC;
  localparam int V_SYNC_START = DEF_V_VIS + DEF_V_FP;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2
  } mon_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/crc16_step6.sv
// One CRC-16-CCITT update over six data bits, MSB first.
// Purely combinational.
module crc16_step6
  import vga_stream_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [5:0]  i_data,
  output logic [15:0] o_crc
);

  logic [15:0] c;

  always_comb begin
    c = i_crc;
    for (int i = 5; i >= 0; i--) begin
      if (c[15] ^ i_data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else c = {c[14:0], 1'b0};
    end
    o_crc = c;
  end

endmodule

// File: rtl/vga_stream_monitor.sv
// Decodes a TinyVGA PMOD byte, locks to its timing and signs frames.
// Define VGA_STREAM_MONITOR_CRC_EN to build the frame CRC.
module vga_stream_monitor
  import vga_stream_pkg::*;
#(
  parameter int H_VIS = DEF_H_VIS,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_VIS = DEF_V_VIS,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_vga,
  output logic        o_locked,
  output logic [9:0]  o_hpos,
  output logic [9:0]  o_vpos,
  output logic        o_pix_valid,
  output logic [5:0]  o_color,
  output logic        o_frame_done,
  output logic [15:0] o_frame_crc,
  output logic        o_err_h,
  output logic        o_err_v,
  output logic [7:0]  o_frame_count
);

  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] HSS = 10'(H_VIS + H_FP);
  localparam logic [9:0] HSE = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VSS = 10'(V_VIS + V_FP);
  localparam logic [9:0] HLAST = 10'(HT - 1);
  localparam logic [9:0] VLAST = 10'(VT - 1);
  localparam logic [9:0] HVIS = 10'(H_VIS);
  localparam logic [9:0] VVIS = 10'(V_VIS);
  localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);

  logic [7:0]  s1_q, s1_d, s2_q, s2_d;
  logic [9:0]  h_q, h_d, v_q, v_d;
  mon_state_e  state_q, state_d;
  logic [2:0]  good_q, good_d;
  logic        vseen_q, vseen_d;
  logic        done_q, done_d;
  logic [15:0] fcrc_q, fcrc_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        errh_q, errh_d;
  logic        errv_q, errv_d;

  logic        hs_fall, hs_rise, vs_fall;
  logic        h_wrap, h_bad, v_bad, viol;
  logic [9:0]  h_inc, v_inc;
  logic [5:0]  color;
  logic        pix_valid, frame_end;
  logic [15:0] crc_cur;

  // s1 holds the newest sample, s2 the one the counters describe
  always_comb begin
    s1_d = i_vga;
    s2_d = s1_q;
    hs_fall = s2_q[7] & ~s1_q[7];
    hs_rise = ~s2_q[7] & s1_q[7];
    vs_fall = s2_q[3] & ~s1_q[3];
    color = {s2_q[0], s2_q[4], s2_q[1],
             s2_q[5], s2_q[2], s2_q[6]};
    h_wrap = (h_q == HLAST);
    h_inc = h_wrap ? 10'd0 : h_q + 10'd1;
    v_inc = v_q;
    if (h_wrap) v_inc = (v_q == VLAST) ? 10'd0 : v_q + 10'd1;
    h_bad = (hs_fall && h_inc != HSS) ||
            (hs_rise && h_inc != HSE);
    v_bad = vs_fall && (h_inc != 10'd0 || v_inc != VSS);
    viol = h_bad | v_bad;
    pix_valid = (state_q == LOCKED) &&
                (h_q < HVIS) && (v_q < VVIS);
  end

  always_comb begin
    h_d = h_inc;
    v_d = v_inc;
    if (hs_fall) h_d = HSS;
    if (vs_fall) begin
      h_d = 10'd0;
      v_d = VSS;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d = good_q;
    vseen_d = vseen_q;
    errh_d = errh_q;
    errv_d = errv_q;
    frame_end = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = TRAIN;
          good_d = 3'd0;
          vseen_d = 1'b0;
        end
      end
      TRAIN: begin
        if (vs_fall) begin
          vseen_d = 1'b0;
          if (viol || vseen_q) begin
            good_d = 3'd0;
          end else if (good_q + 3'd1 == LOCK_N) begin
            state_d = LOCKED;
            good_d = 3'd0;
            frame_end = 1'b1;
          end else begin
            good_d = good_q + 3'd1;
          end
        end else if (viol) begin
          good_d = 3'd0;
          vseen_d = 1'b1;
        end
      end
      LOCKED: begin
        if (viol) begin
          state_d = SEARCH;
          errh_d = errh_q | h_bad;
          errv_d = errv_q | v_bad;
        end else if (vs_fall) begin
          frame_end = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    done_d = frame_end;
    fcrc_d = fcrc_q;
    fcnt_d = fcnt_q;
    if (frame_end) begin
      fcrc_d = crc_cur;
      fcnt_d = fcnt_q + 8'd1;
    end
  end

`ifdef VGA_STREAM_MONITOR_CRC_EN
  logic [15:0] crc_q, crc_d, crc_step;

  crc16_step6 u_crc (
    .i_crc (crc_q),
    .i_data(color),
    .o_crc (crc_step)
  );

  // restart whenever not locked so a relock never reports stale pixels
  always_comb begin
    crc_cur = crc_q;
    crc_d = crc_q;
    if (state_q != LOCKED || frame_end) crc_d = CRC_INIT;
    else if (pix_valid) crc_d = crc_step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC_INIT;
    else crc_q <= crc_d;
  end
`else
  always_comb crc_cur = 16'h0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      h_q <= '0;
      v_q <= '0;
      state_q <= SEARCH;
      good_q <= '0;
      vseen_q <= 1'b0;
      done_q <= 1'b0;
      fcrc_q <= '0;
      fcnt_q <= '0;
      errh_q <= 1'b0;
      errv_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      h_q <= h_d;
      v_q <= v_d;
      state_q <= state_d;
      good_q <= good_d;
      vseen_q <= vseen_d;
      done_q <= done_d;
      fcrc_q <= fcrc_d;
      fcnt_q <= fcnt_d;
      errh_q <= errh_d;
      errv_q <= errv_d;
    end
  end

  assign o_locked = (state_q == LOCKED);
  assign o_hpos = h_q;
  assign o_vpos = v_q;
  assign o_pix_valid = pix_valid;
  assign o_color = color;
  assign o_frame_done = done_q;
  assign o_frame_crc = fcrc_q;
  assign o_err_h = errh_q;
  assign o_err_v = errv_q;
  assign o_frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_stream_monitor.sv
// Randomized bench for vga_stream_monitor on a shrunken raster.
// Expected outputs come from a frame-level reference model.
module tb_vga_stream_monitor;

  localparam int HV = 16, HF = 4, HSY = 6, HB = 6;
  localparam int VV = 12, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int HSS = HV + HF;
  localparam int HSE = HSS + HSY;
  localparam int VSS = VV + VF;
  localparam int FR = HT * VT;
  localparam int LOCKN = 2;
  localparam int FLINE = 3;

  typedef enum {K_RAND, K_REP, K_FLIP, K_ZERO, K_FIX, K_HF, K_VF} kind_e;
  typedef enum {MS, MT, ML} mst_e;

  typedef struct {
    logic [5:0]  c;
    bit          lk;
    bit          vis;
    bit          fd;
    bit          eh;
    bit          ev;
    int          col;
    int          line;
    logic [15:0] fcrc;
    logic [7:0]  fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] i_vga = 8'h88;
  logic o_locked, o_pix_valid, o_frame_done, o_err_h, o_err_v;
  logic [9:0] o_hpos, o_vpos;
  logic [5:0] o_color;
  logic [15:0] o_frame_crc;
  logic [7:0] o_frame_count;

  always #5 clk = ~clk;

  vga_stream_monitor #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .LOCK_FRAMES(LOCKN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_vga(i_vga),
    .o_locked(o_locked), .o_hpos(o_hpos), .o_vpos(o_vpos),
    .o_pix_valid(o_pix_valid), .o_color(o_color),
    .o_frame_done(o_frame_done), .o_frame_crc(o_frame_crc),
    .o_err_h(o_err_h), .o_err_v(o_err_v),
    .o_frame_count(o_frame_count)
  );

  int errs = 0;
  int checks = 0;
  int cur_n = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s n=%0d: got %0h want %0h",
               tag, cur_n, got, want);
    end
  endtask

  function automatic logic [15:0] crc6(input logic [15:0] c,
                                       input logic [5:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 5; i >= 0; i--)
      r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [5:0] content(input kind_e k,
      input logic [31:0] s, input int col, input int line);
    logic [31:0] x;
    if (k == K_ZERO) return 6'h00;
    if (k == K_FIX) return 6'h31;
    if (k == K_FLIP && col == HV / 2 && line == VV / 2) return 6'h3F;
    x = s ^ (32'(col) * 32'h9E3779B1) ^ (32'(line) * 32'h85EBCA6B);
    x = x ^ (x >> 15);
    x = x * 32'h2C1B3C6D;
    x = x ^ (x >> 12);
    return x[5:0];
  endfunction

  mst_e mst;
  int good;
  bit vseen, meh, mev;
  logic [15:0] mcrc, mfcrc;
  logic [7:0] mfcnt;
  logic [31:0] seed, pseed;
  exp_t ring [4];
  kind_e plan [$];

  task automatic model_reset();
    mst = MS;
    good = 0;
    vseen = 0;
    meh = 0;
    mev = 0;
    mcrc = 16'hFFFF;
    mfcrc = 16'h0;
    mfcnt = 8'h0;
    pseed = 32'h1234_5678;
  endtask

  task automatic frame_end_model();
`ifdef VGA_STREAM_MONITOR_CRC_EN
    mfcrc = mcrc;
`else
    mfcrc = 16'h0;
`endif
    mfcnt = mfcnt + 8'd1;
    mcrc = 16'hFFFF;
  endtask

  task automatic check_out(input exp_t e);
    chk("color", 32'(o_color), 32'(e.c));
    chk("locked", 32'(o_locked), 32'(e.lk));
    chk("pix_valid", 32'(o_pix_valid), 32'(e.lk & e.vis));
    if (e.lk) begin
      chk("hpos", 32'(o_hpos), 32'(e.col));
      chk("vpos", 32'(o_vpos), 32'(e.line));
    end
    chk("frame_done", 32'(o_frame_done), 32'(e.fd));
    chk("frame_crc", 32'(o_frame_crc), 32'(e.fcrc));
    chk("frame_count", 32'(o_frame_count), 32'(e.fcnt));
    chk("err_h", 32'(o_err_h), 32'(e.eh));
    chk("err_v", 32'(o_err_v), 32'(e.ev));
  endtask

  task automatic check_reset_state();
    chk("rst locked", 32'(o_locked), 0);
    chk("rst hpos", 32'(o_hpos), 0);
    chk("rst vpos", 32'(o_vpos), 0);
    chk("rst pix_valid", 32'(o_pix_valid), 0);
    chk("rst color", 32'(o_color), 0);
    chk("rst frame_done", 32'(o_frame_done), 0);
    chk("rst frame_crc", 32'(o_frame_crc), 0);
    chk("rst err_h", 32'(o_err_h), 0);
    chk("rst err_v", 32'(o_err_v), 0);
    chk("rst frame_count", 32'(o_frame_count), 0);
  endtask

  // stop_n < 0 runs every planned frame to completion
  task automatic run_stream(input int stop_n);
    int total;
    total = plan.size() * FR;
    for (int n = 0; n < total; n++) begin
      kind_e k;
      int col, line, vst, hse;
      bit vis, hs_low, vs_low, hviol, vedge;
      logic [5:0] c;
      exp_t e;
      @(posedge clk);
      #1;
      cur_n = n;
      if (n >= 2) check_out(ring[(n - 2) % 4]);
      if (n == stop_n) return;
      k = plan[n / FR];
      col = n % HT;
      line = (n / HT) % VT;
      if (col == 0 && line == 0) begin
        if (k == K_REP || k == K_FLIP) seed = pseed;
        else seed = $urandom;
        pseed = seed;
      end
      vis = (col < HV) && (line < VV);
      c = vis ? content(k, seed, col, line) : 6'($urandom);
      hse = (k == K_HF && line == FLINE) ? HSE - 1 : HSE;
      vst = (k == K_VF) ? VSS + 1 : VSS;
      hs_low = (col >= HSS) && (col < hse);
      vs_low = (line >= vst) && (line < vst + VSY);
      i_vga = {~hs_low, c[0], c[2], c[4], ~vs_low, c[1], c[3], c[5]};
      hviol = (k == K_HF) && (line == FLINE) && (col == HSE - 1);
      vedge = (col == 0) && (line == vst);
      e.fd = 0;
      if (hviol) begin
        if (mst == ML) begin
          mst = MS;
          meh = 1;
        end else if (mst == MT) begin
          good = 0;
          vseen = 1;
        end
      end
      if (vedge) begin
        case (mst)
          MS: begin
            mst = MT;
            good = 0;
            vseen = 0;
          end
          MT: begin
            if (k == K_VF || vseen) good = 0;
            else good++;
            vseen = 0;
            if (good == LOCKN) begin
              mst = ML;
              good = 0;
              e.fd = 1;
              frame_end_model();
            end
          end
          default: begin
            if (k == K_VF) begin
              mst = MS;
              mev = 1;
            end else begin
              e.fd = 1;
              frame_end_model();
            end
          end
        endcase
      end
      e.lk = (mst == ML);
      if (!e.lk) mcrc = 16'hFFFF;
      else if (vis) mcrc = crc6(mcrc, c);
      e.c = c;
      e.vis = vis;
      e.col = col;
      e.line = line;
      e.eh = meh;
      e.ev = mev;
      e.fcrc = mfcrc;
      e.fcnt = mfcnt;
      ring[n % 4] = e;
    end
  endtask

  initial begin
    model_reset();
    #2;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    plan = '{K_RAND, K_RAND, K_RAND, K_RAND, K_REP, K_FLIP,
             K_ZERO, K_FIX, K_HF, K_RAND, K_RAND, K_RAND,
             K_VF, K_RAND, K_RAND, K_RAND, K_RAND};
    run_stream(16 * FR + 5 * HT + 7);

    rst_n = 1'b0;
    #1;
    check_reset_state();
    i_vga = 8'h88;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    plan = '{K_RAND, K_RAND, K_RAND, K_REP, K_RAND};
    run_stream(-1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
